// File: rtl/gpr_pkg.sv
// Shared processor datapath definitions: data width, register file depth,
// and the operand/select types used across the datapath.
package gpr_pkg;

   localparam int DATA_W    = 8;
   localparam int GPR_DEPTH = 8;
   localparam int GPR_SEL_W = 3;

   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [GPR_SEL_W-1:0] gpr_sel_t;

endpackage : gpr_pkg

// File: rtl/gpr.sv
// General-purpose register file: one synchronous write port addressed by
// rd_sel and two combinational read ports (rd_out, rs_out), no write bypass.
module gpr
   import gpr_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = GPR_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [$clog2(DEPTH)-1:0] rd_sel,
   input  logic [$clog2(DEPTH)-1:0] rs_sel,
   input  logic                     gpr_load,
   output logic [WIDTH-1:0]         rd_out,
   output logic [WIDTH-1:0]         rs_out
);

   logic [WIDTH-1:0] regs [DEPTH];

   // NOTE: the storage is a flop array rather than RAM, so it can be cleared
   // by reset; reset is checked first so it always beats a concurrent write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (gpr_load) begin
         regs[rd_sel] <= data_in;
      end
   end

   // Reads see the stored value only, so a write shows up after its edge.
   assign rd_out = regs[rd_sel];
   assign rs_out = regs[rs_sel];

endmodule : gpr

// File: tb/tb_gpr.sv
// Directed self-checking bench for the gpr register file: reset clear,
// write/readback, hold, independent read ports, no bypass, reset priority.
module tb_gpr;
   import gpr_pkg::*;

   logic     clk;
   logic     rst_n;
   data_t    data_in;
   gpr_sel_t rd_sel;
   gpr_sel_t rs_sel;
   logic     gpr_load;
   data_t    rd_out;
   data_t    rs_out;

   int n_checks = 0;
   int n_passed = 0;

   gpr dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .rd_sel   (rd_sel),
      .rs_sel   (rs_sel),
      .gpr_load (gpr_load),
      .rd_out   (rd_out),
      .rs_out   (rs_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input data_t observed, input data_t expected);
      n_checks++;
      if (observed === expected) begin
         n_passed++;
      end else begin
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input gpr_sel_t sel, input data_t value, input int cycles);
      gpr_load = 1'b1;
      data_in  = value;
      rd_sel   = sel;
      rs_sel   = sel;
      repeat (cycles) tick();
      gpr_load = 1'b0;
   endtask

   task automatic sweep(input string tag, input data_t exp0, input data_t exp1,
                        input data_t exp2, input data_t exp3, input data_t exp4,
                        input data_t exp5, input data_t exp6, input data_t exp7);
      data_t expv [8];
      expv = '{exp0, exp1, exp2, exp3, exp4, exp5, exp6, exp7};
      for (int i = 0; i < 8; i++) begin
         rd_sel = gpr_sel_t'(i);
         rs_sel = gpr_sel_t'(7 - i);
         #1;
         check($sformatf("%s rd r%0d", tag, i), rd_out, expv[i]);
         check($sformatf("%s rs r%0d", tag, 7 - i), rs_out, expv[7 - i]);
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      data_in  = 8'h00;
      rd_sel   = 3'd0;
      rs_sel   = 3'd0;
      gpr_load = 1'b0;
      tick();

      // Reset clears every register.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sweep("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      // Write and read back.
      write_reg(3'd0, 8'h8E, 3);
      write_reg(3'd1, 8'h8E, 3);
      write_reg(3'd2, 8'h8E, 3);
      write_reg(3'd3, 8'h9B, 3);
      write_reg(3'd4, 8'h9B, 3);
      sweep("write", 8'h8E, 8'h8E, 8'h8E, 8'h9B, 8'h9B, 8'h00, 8'h00, 8'h00);

      // Hold: enable low, data bus at 0xFF, selects moving across edges.
      gpr_load = 1'b0;
      data_in  = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         rd_sel = gpr_sel_t'(i);
         rs_sel = gpr_sel_t'(i);
         tick();
      end
      sweep("hold", 8'h8E, 8'h8E, 8'h8E, 8'h9B, 8'h9B, 8'h00, 8'h00, 8'h00);

      // Independent ports, swapped without a clock edge.
      write_reg(3'd5, 8'h33, 1);
      @(negedge clk);
      rd_sel = 3'd2;
      rs_sel = 3'd5;
      #1;
      check("ports rd=r2", rd_out, 8'h8E);
      check("ports rs=r5", rs_out, 8'h33);
      rd_sel = 3'd5;
      rs_sel = 3'd2;
      #1;
      check("swap rd=r5", rd_out, 8'h33);
      check("swap rs=r2", rs_out, 8'h8E);

      // No bypass: old value before the edge, new value right after.
      @(negedge clk);
      gpr_load = 1'b1;
      data_in  = 8'h55;
      rd_sel   = 3'd1;
      rs_sel   = 3'd1;
      #1;
      check("bypass before rd", rd_out, 8'h8E);
      check("bypass before rs", rs_out, 8'h8E);
      tick();
      gpr_load = 1'b0;
      check("bypass after rd", rd_out, 8'h55);
      check("bypass after rs", rs_out, 8'h55);
      rs_sel = 3'd0;
      #1;
      check("bypass neighbor r0", rs_out, 8'h8E);

      // Reset wins over a concurrent write.
      @(negedge clk);
      rst_n    = 1'b0;
      gpr_load = 1'b1;
      data_in  = 8'hAA;
      rd_sel   = 3'd3;
      rs_sel   = 3'd3;
      #1;
      check("rstprio before r3", rd_out, 8'h9B);
      tick();
      rst_n    = 1'b1;
      gpr_load = 1'b0;
      check("rstprio after r3", rd_out, 8'h00);
      sweep("rstprio", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule : tb_gpr
